// File: rtl/mm_stream_tx.sv
// mm_stream_tx: reads a packed operand packet from a 1-cycle-latency RAM
// and streams it out as one AXI-stream packet through a 2-entry skid FIFO.
module mm_stream_tx #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [31:0]       m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [CNT_W-1:0]   num_q;
  logic [CNT_W-1:0]   issued_q;   // reads issued in this packet
  logic [CNT_W-1:0]   popped_q;   // beats accepted; equals index of head word
  logic               rd_vld_q;   // a read is in flight, data arrives this cycle
  logic [31:0]        mem_q [2];
  logic               wptr_q, rptr_q;
  logic [1:0]         cnt_q;

  logic       start_acc, push, pop, last_head;
  logic [2:0] credit_after;

  assign start_acc     = (state_q == IDLE) && start;
  assign push          = rd_vld_q;
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata  = mem_q[rptr_q];
  assign last_head     = (popped_q == num_q - CNT_W'(1));
  assign m_axis_tlast  = m_axis_tvalid && last_head;
  assign busy          = (state_q == RUN);
  assign done          = (state_q == FIN);
  assign rd_addr       = base_q + ADDR_W'(issued_q);

  // Credit counts stored words plus the read landing this cycle, minus this
  // cycle's pop; a new read only goes out if it still has a slot next cycle.
  assign credit_after  = 3'(cnt_q) + 3'(rd_vld_q) - 3'(pop);
  assign rd_en         = (state_q == RUN) && (issued_q < num_q) && (credit_after < 3'd2);

  // Next-state logic: zero-length packets go straight to FIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = (num_words == '0) ? FIN : RUN;
      RUN:  if (pop && last_head) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Packet parameters and progress counters; cleared on each accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q   <= '0;
      num_q    <= '0;
      issued_q <= '0;
      popped_q <= '0;
    end else if (start_acc) begin
      base_q   <= base_addr;
      num_q    <= num_words;
      issued_q <= '0;
      popped_q <= '0;
    end else begin
      if (rd_en) issued_q <= issued_q + CNT_W'(1);
      if (pop)   popped_q <= popped_q + CNT_W'(1);
    end
  end

  // Read-in-flight flag; reset drops any outstanding read so its data is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_vld_q <= 1'b0;
    else     rd_vld_q <= rd_en;
  end

  // Skid FIFO storage and pointers; push and pop together leave occupancy unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= rd_data;
        wptr_q        <= ~wptr_q;
      end
      if (pop) rptr_q <= ~rptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_mm_stream_tx.sv
// Bench for mm_stream_tx: table of packets checked against a RAM model and
// a beat-by-beat scoreboard, plus hand-written reset sequences.
module tb_mm_stream_tx;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int NV     = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [CNT_W-1:0]  num_words;
  logic              busy, done, rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data = '0;
  logic [31:0]       tdata;
  logic              tvalid, tready, tlast;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ram [1024];

  typedef struct {
    int base;     // packet start address
    int len;      // words
    int pct;      // tready probability in percent
    int restart;  // cycle of ignored second start (0 = none)
    int exp_fv;   // expected first tvalid cycle (-1 = not checked)
    int done_lo;  // done cycle window (-1 = not checked)
    int done_hi;
  } vec_t;

  vec_t vecs [NV];

  mm_stream_tx #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tlast(tlast)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of read latency.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_busy"},   busy,   0);
    chk({nm, "_done"},   done,   0);
    chk({nm, "_rd_en"},  rd_en,  0);
    chk({nm, "_rdaddr"}, rd_addr, 0);
    chk({nm, "_tvalid"}, tvalid, 0);
    chk({nm, "_tlast"},  tlast,  0);
    chk({nm, "_tdata"},  tdata,  0);
  endtask

  task automatic run_pkt(input vec_t v);
    int nissued, nbeats, ndone, done_cyc, last_cyc, first_vld, budget;
    logic pv, pb, pl, beat;
    logic [31:0] pd;
    nissued = 0; nbeats = 0; ndone = 0; done_cyc = -1; last_cyc = -1; first_vld = -1;
    pv = 1'b0; pb = 1'b0; pl = 1'b0; pd = '0;
    budget = v.len * 8 + 40;
    @(negedge clk);
    base_addr = ADDR_W'(v.base);
    num_words = CNT_W'(v.len);
    start     = 1'b1;
    tready    = ($urandom_range(99) < v.pct);
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (v.restart != 0 && cyc == v.restart) begin
        start = 1'b1; base_addr = 10'h200; num_words = 16'd3;
      end
      if (v.restart != 0 && cyc == v.restart + 1) start = 1'b0;
      tready = ($urandom_range(99) < v.pct);
      #1;
      beat = tvalid && tready;
      if (pv && !pb) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_tdata",  tdata,  pd);
        chk("hold_tlast",  tlast,  pl);
      end
      chk("busy", busy, (v.len != 0) && (ndone == 0) && !done);
      if (rd_en) begin
        chk("rd_addr", rd_addr, (v.base + nissued) % 1024);
        nissued++;
      end
      if (tvalid && first_vld < 0) first_vld = cyc;
      if (beat) begin
        chk("tdata", tdata, ram[(v.base + nbeats) % 1024]);
        chk("tlast", tlast, (nbeats == v.len - 1));
        nbeats++;
        last_cyc = cyc;
      end
      chk("credit", (nissued - nbeats) <= 2, 1);
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      pv = tvalid; pb = beat; pd = tdata; pl = tlast;
      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
    end
    chk("done_count", ndone, 1);
    chk("beats", nbeats, v.len);
    chk("reads", nissued, v.len);
    if (v.len > 0) chk("done_after_last", done_cyc, last_cyc + 1);
    if (v.exp_fv >= 0) chk("first_tvalid", first_vld, v.exp_fv);
    if (v.done_lo >= 0) chk("done_cycle", (done_cyc >= v.done_lo) && (done_cyc <= v.done_hi), 1);
  endtask

  initial begin
    vec_t t1;
    int nbeats;
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA0A0_0000 + i;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0; tready = 1'b0;

    // Table: base, len, tready%, restart, first tvalid, done window.
    vecs[0] = '{base: 'h010, len: 8, pct: 100, restart: 0, exp_fv: 3,  done_lo: 11, done_hi: 11};
    vecs[1] = '{base: 'h010, len: 8, pct: 50,  restart: 0, exp_fv: -1, done_lo: -1, done_hi: -1};
    vecs[2] = '{base: 'h123, len: 1, pct: 100, restart: 0, exp_fv: 3,  done_lo: 4,  done_hi: 4};
    vecs[3] = '{base: 'h040, len: 0, pct: 100, restart: 0, exp_fv: -1, done_lo: 1,  done_hi: 2};
    vecs[4] = '{base: 'h010, len: 8, pct: 100, restart: 4, exp_fv: 3,  done_lo: 11, done_hi: 11};
    vecs[5] = '{base: 'h3FE, len: 4, pct: 100, restart: 0, exp_fv: 3,  done_lo: 7,  done_hi: 7};
    for (int i = 6; i < NV; i++) begin
      vecs[i] = '{base: int'($urandom_range(1023)), len: int'($urandom_range(20, 1)),
                  pct: int'($urandom_range(90, 30)), restart: 0, exp_fv: -1,
                  done_lo: -1, done_hi: -1};
    end

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_pkt(vecs[i]);

    // Scrambled RAM contents for a second random pass.
    for (int i = 0; i < 1024; i++) ram[i] = $urandom;
    for (int i = 6; i < NV; i++) run_pkt(vecs[i]);

    // Mid-packet asynchronous reset after the third beat.
    for (int i = 0; i < 1024; i++) ram[i] = 32'hA0A0_0000 + i;
    @(negedge clk);
    base_addr = 10'h010; num_words = 16'd8; start = 1'b1; tready = 1'b1;
    nbeats = 0;
    for (int cyc = 1; cyc <= 20 && nbeats < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("abort_no_done", done, 0);
      if (tvalid && tready) nbeats++;
    end
    chk("abort_beats", nbeats, 3);
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    t1 = vecs[0];
    run_pkt(t1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
